// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch stage: fetches over req/ack, holds one instruction,
// and loads the resolved next PC (jump > branch > pc+4) when downstream consumes.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  input  logic        take_jump,
  input  logic [31:0] jump_target,
  output logic        misalign_err,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] sel_target;
  logic        ack_take;
  logic        consume;

  assign imem_addr = pc;
  assign ack_take  = (state == FETCH) && imem_ack;
  assign consume   = (state == HOLD) && instr_ready;

  always_comb begin
    sel_target = pc_plus4;
    if (take_jump)
      sel_target = jump_target;
    else if (take_branch)
      sel_target = branch_target;
  end

  // imem_req and instr_valid are registered alongside state so no input reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      instr         <= 32'h0;
      instr_pc      <= 32'h0;
      pc_plus4      <= 32'h0;
      misalign_err  <= 1'b0;
      retired_count <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (ack_take) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc_plus4    <= pc + 32'd4;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (consume) begin
            // Misaligned targets are truncated to a word boundary and flagged stickily.
            pc            <= {sel_target[31:2], 2'b00};
            retired_count <= retired_count + 32'd1;
            if (sel_target[1:0] != 2'b00)
              misalign_err <= 1'b1;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b1;
            state         <= FETCH;
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
